// File: rtl/spi_pkg.sv
// Purpose : shared types and sizes for the SPI frame receiver.
// Latency : n/a (declarations only).
// Backpressure: n/a; the SPI master cannot be stalled.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    OVERRUN
  } spi_state_t;

  localparam int FRAME_BYTES = 3;
  localparam int BYTE_W      = 8;

  // One decoded frame, byte 0 in the most significant position.
  typedef struct packed {
    logic [BYTE_W-1:0] command;
    logic [BYTE_W-1:0] databyte1;
    logic [BYTE_W-1:0] databyte2;
  } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Purpose : synchronise one async input into clk and flag its rising edge.
// Latency : level valid STAGES clk after the pin; rise is combinational off the last stage.
// Backpressure: none; every sampled transition is reported.
//
// Ports:
//   clk, reset : system clock, async active-high reset
//   d          : asynchronous input
//   level      : synchronised copy of d
//   rise       : one-cycle pulse when level goes 0->1
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_sr;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_sr <= {STAGES{RST_VAL}};
      prev    <= RST_VAL;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
      prev    <= sync_sr[STAGES-1];
    end
  end

  assign level = sync_sr[STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// Purpose : SPI mode-0 slave assembling 3-byte {command, databyte1, databyte2} frames.
// Latency : spi_done rises SYNC_STAGES+1 clk after the 24th sck rising edge at the pin.
// Backpressure: none; malformed frames are dropped, pulsed on frame_err and counted.
//
// Ports:
//   clk, reset         : system clock (>= 8x sck), async active-high reset
//   sck, cs_n, sdi     : asynchronous SPI pins from the MCU
//   command/databyte*  : last good frame, held until the next spi_done
//   spi_done           : 1-cycle pulse, outputs just updated
//   frame_err          : 1-cycle pulse, frame aborted or overrun
//   err_count          : saturating count of frame_err pulses
module spi_frame_receiver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              sdi,
  output logic [BYTE_W-1:0] command,
  output logic [BYTE_W-1:0] databyte1,
  output logic [BYTE_W-1:0] databyte2,
  output logic              spi_done,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  logic sck_s, sck_rise;
  logic cs_n_s, cs_rise;
  logic sdi_s, sdi_rise_unused;

  // All three pins share one depth so sdi stays aligned with the sck edge.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck), .level(sck_s), .rise(sck_rise)
  );
  // cs_n resets to the deselected level so leaving reset never looks like a select.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs_n), .level(cs_n_s), .rise(cs_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi), .level(sdi_s), .rise(sdi_rise_unused)
  );

  spi_state_t        state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_idx;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] byte_buf [FRAME_BYTES-1];
  logic              ovr_seen;
  frame_t            frame_q;

  logic              sck_live;
  logic [BYTE_W-1:0] new_byte;
  logic              clr, shift_en, byte_done, frame_done, err_nxt, ovr_set;

  // A select released in the same cycle gates the sck edge away.
  assign sck_live = sck_rise & ~cs_n_s;
  assign new_byte = {shreg[BYTE_W-2:0], sdi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    clr        = 1'b0;
    shift_en   = 1'b0;
    byte_done  = 1'b0;
    frame_done = 1'b0;
    err_nxt    = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (!cs_n_s) state_nxt = RECV;
      end
      RECV: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (sck_live) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            if (byte_idx == LAST_IDX) begin
              frame_done = 1'b1;
              state_nxt  = OVERRUN;
            end else begin
              byte_done = 1'b1;
            end
          end
        end
      end
      OVERRUN: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          err_nxt   = ovr_seen;
        end else if (sck_live) begin
          ovr_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      byte_buf[0] <= '0;
      byte_buf[1] <= '0;
      ovr_seen    <= 1'b0;
      frame_q     <= '0;
      spi_done    <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      if (clr) begin
        bit_cnt  <= '0;
        byte_idx <= '0;
        ovr_seen <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= new_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        byte_buf[byte_idx[0]] <= new_byte;
        byte_idx              <= byte_idx + 2'd1;
      end
      // The last byte is taken straight from the shifter so all three load together.
      if (frame_done) frame_q <= {byte_buf[0], byte_buf[1], new_byte};
      if (ovr_set) ovr_seen <= 1'b1;
      spi_done  <= frame_done;
      frame_err <= err_nxt;
      if (err_nxt && (err_count != {ERR_W{1'b1}})) err_count <= err_count + ERR_W'(1);
    end
  end

  assign command   = frame_q.command;
  assign databyte1 = frame_q.databyte1;
  assign databyte2 = frame_q.databyte2;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Purpose : directed and random SPI frames checked against a frame-level model.
// Latency : spi_done expected (SYNC_STAGES+1) clk after the 24th sck rise.
// Backpressure: n/a.
module tb_spi_frame_receiver;

  localparam int CLK_NS   = 10;
  localparam int SCK_HALF = 40;   // sck = clk/8
  localparam int GAP_NS   = 160;  // two sck periods between windows
  localparam int SYNC     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic sdi = 1'b0;

  logic [7:0] command, databyte1, databyte2;
  logic       spi_done, frame_err;
  logic [7:0] err_count;
  logic [7:0] s_command, s_databyte1, s_databyte2;
  logic       s_spi_done, s_frame_err;
  logic [1:0] s_err_count;

  spi_frame_receiver #(.SYNC_STAGES(SYNC), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
    .command(command), .databyte1(databyte1), .databyte2(databyte2),
    .spi_done(spi_done), .frame_err(frame_err), .err_count(err_count)
  );

  spi_frame_receiver #(.SYNC_STAGES(SYNC), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
    .command(s_command), .databyte1(s_databyte1), .databyte2(s_databyte2),
    .spi_done(s_spi_done), .frame_err(s_frame_err), .err_count(s_err_count)
  );

  always #(CLK_NS/2) clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  tx [5];
  int          bitpos;
  time         t24 = 0;
  time         last_lat = 0;
  logic [23:0] last_done_frame = '0;
  logic [23:0] exp_frame = '0;
  int          exp_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic tx_bit(input int p);
    logic [7:0] b;
    b = tx[p / 8];
    return b[7 - (p % 8)];
  endfunction

  // Pulse monitor: counts high cycles, so a stretched pulse shows as an extra event.
  always @(negedge clk) begin
    if (spi_done) begin
      done_cnt++;
      last_done_frame = {command, databyte1, databyte2};
      last_lat        = $time - t24;
    end
    if (frame_err) err_cnt++;
    if (spi_done || frame_err) check("done_err_exclusive", {31'b0, spi_done & frame_err}, 32'd0);
  end

  task automatic set_tx(input logic [7:0] a, b, c, d, e);
    tx[0] = a; tx[1] = b; tx[2] = c; tx[3] = d; tx[4] = e;
  endtask

  task automatic start_window();
    @(negedge clk);
    cs_n   = 1'b0;
    bitpos = 0;
    #SCK_HALF;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sdi = tx_bit(bitpos);
      #SCK_HALF;
      sck = 1'b1;
      bitpos++;
      if (bitpos == 24) t24 = $time;
      #SCK_HALF;
      sck = 1'b0;
    end
  endtask

  task automatic end_window();
    #SCK_HALF;
    cs_n = 1'b1;
    #GAP_NS;
  endtask

  task automatic verify(input string tag, input bit xd, input bit xe, input int d0, input int e0);
    check({tag, ".done"}, done_cnt - d0, {31'b0, xd});
    check({tag, ".err"}, err_cnt - e0, {31'b0, xe});
    check({tag, ".frame"}, {8'h0, command, databyte1, databyte2}, {8'h0, exp_frame});
    check({tag, ".errcnt"}, {24'h0, err_count}, sat(exp_errs, 255));
    check({tag, ".errcnt_sat"}, {30'h0, s_err_count}, sat(exp_errs, 3));
    check({tag, ".frame_sat"}, {8'h0, s_command, s_databyte1, s_databyte2}, {8'h0, exp_frame});
    if (xd) begin
      check({tag, ".done_frame"}, {8'h0, last_done_frame}, {8'h0, exp_frame});
      check({tag, ".latency"}, 32'(last_lat), (SYNC + 1) * CLK_NS);
    end
  endtask

  // Model: exactly 24 bits is good; more is a good frame then an overrun error; fewer is an abort.
  task automatic run_window(input string tag, input int nbits, input int hold_ns);
    int d0, e0;
    bit xd, xe;
    d0 = done_cnt;
    e0 = err_cnt;
    start_window();
    send_bits(nbits);
    #hold_ns;
    end_window();
    xd = (nbits >= 24);
    xe = (nbits != 24);
    if (xd) exp_frame = {tx[0], tx[1], tx[2]};
    if (xe) exp_errs++;
    verify(tag, xd, xe, d0, e0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cs_n  = 1'b1;
    sck   = 1'b0;
    #(3 * CLK_NS);
    check("rst.frame", {8'h0, command, databyte1, databyte2}, 32'h0);
    check("rst.pulses", {30'h0, spi_done, frame_err}, 32'h0);
    check("rst.errcnt", {24'h0, err_count}, 32'h0);
    check("rst.errcnt_sat", {30'h0, s_err_count}, 32'h0);
    reset     = 1'b0;
    exp_frame = '0;
    exp_errs  = 0;
    #(5 * CLK_NS);
  endtask

  initial begin
    int d0, e0, nb;

    do_reset();

    // Good frame, held with cs_n low long after: no spurious done.
    set_tx(8'h10, 8'h03, 8'h9C, 8'h00, 8'h00);
    run_window("good", 24, 400);

    set_tx(8'h21, 8'h05, 8'h00, 8'h00, 8'h00);
    run_window("short", 16, 0);

    // Reset in the middle of a frame drops it silently.
    set_tx(8'hAA, 8'h55, 8'hC3, 8'h00, 8'h00);
    d0 = done_cnt;
    e0 = err_cnt;
    start_window();
    send_bits(12);
    do_reset();
    check("midrst.done", done_cnt - d0, 32'd0);
    check("midrst.err", err_cnt - e0, 32'd0);
    run_window("after_rst", 24, 0);

    set_tx(8'h22, 8'h01, 8'h07, 8'hFF, 8'h00);
    run_window("overrun", 32, 0);

    set_tx(8'h31, 8'h41, 8'h59, 8'h00, 8'h00);
    run_window("b2b_a", 24, 0);
    set_tx(8'h26, 8'h53, 8'h58, 8'h00, 8'h00);
    run_window("b2b_b", 24, 0);

    // Saturation of the 2-bit counter: 1,2,3,3,3.
    do_reset();
    set_tx(8'h12, 8'h34, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) run_window("sat", 16, 0);

    // Last sck edge coincides with cs_n release: edge is not taken, frame aborts.
    set_tx(8'h5A, 8'hA5, 8'h3C, 8'h00, 8'h00);
    d0 = done_cnt;
    e0 = err_cnt;
    start_window();
    send_bits(23);
    sdi = tx_bit(23);
    #SCK_HALF;
    sck  = 1'b1;
    cs_n = 1'b1;
    #SCK_HALF;
    sck = 1'b0;
    #GAP_NS;
    exp_errs++;
    verify("simul", 1'b0, 1'b1, d0, e0);

    for (int i = 0; i < 12; i++) begin
      set_tx(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      nb = ($urandom_range(0, 2) != 0) ? 24 : int'($urandom_range(0, 40));
      run_window("rand", nb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
